// File: rtl/mmu_result_monitor.sv
// ---------------------------------------------------------------------------
// mmu_result_monitor
//
// Consumes the 64-bit result stream of the mmu through a valid/ready
// handshake. Accepted words go into a small FIFO that is drained at a
// throttled rate: one pop every DRAIN_DIV cycles while the FIFO holds data.
// Each drained word is folded into a rotate-XOR signature. When the last
// word of a frame is drained, the signature is compared with EXPECTED_SIG.
// The verdict is shown on the board LEDs.
//
// Ports
//   D_CLK     in   1   clock, all logic on the rising edge
//   D_OFF     in   1   synchronous active-high reset
//   START     in   1   single-cycle pulse that begins a new frame
//   IN_VALID  in   1   upstream result word valid
//   IN_DATA   in   64  result word (bit 0 is the MSB)
//   IN_READY  out  1   a word can be accepted this cycle
//   SIG       out  64  running signature (bit 0 is the MSB)
//   POP_CNT   out  8   words drained in the current frame
//   LED_0     out  1   busy (COLLECT)
//   LED_1     out  1   frame passed
//   LED_2     out  1   frame failed
//
// States
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | after reset, waiting for START
//   ST_COLLECT | accepting and draining words of the current frame
//   ST_PASS    | frame done, signature matched; START begins a new frame
//   ST_FAIL    | frame done, signature differed; START begins a new frame
// ---------------------------------------------------------------------------
module mmu_result_monitor #(
    parameter int          FRAME_WORDS  = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          DRAIN_DIV    = 4,
    parameter logic [63:0] EXPECTED_SIG = 64'h0
) (
    input  logic        D_CLK,
    input  logic        D_OFF,
    input  logic        START,
    input  logic        IN_VALID,
    input  logic [0:63] IN_DATA,
    output logic        IN_READY,
    output logic [0:63] SIG,
    output logic [7:0]  POP_CNT,
    output logic        LED_0,
    output logic        LED_1,
    output logic        LED_2
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    localparam logic [7:0]    FRAME_CNT = 8'(FRAME_WORDS);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DRAIN_DIV - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PASS    = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

    state_t          state_q,    state_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [7:0]      push_cnt_q, push_cnt_d;
    logic [DW-1:0]   div_cnt_q,  div_cnt_d;
    logic [0:63]     sig_q,      sig_d;
    logic [7:0]      pop_cnt_q,  pop_cnt_d;
    logic [2:0]      led_q,      led_d;

    logic [0:63]     mem_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            fifo_full;
    logic            in_ready;
    logic            push;
    logic            pop;
    logic [0:63]     head_word;
    logic [0:63]     sig_next;
    logic [7:0]      pop_cnt_inc;

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready depends only on registered state, so a pop in the same cycle
    // never opens a slot for a full FIFO.
    assign in_ready = (state_q == ST_COLLECT) && !fifo_full &&
                      (push_cnt_q < FRAME_CNT);

    assign push = IN_VALID && in_ready;
    assign pop  = (state_q == ST_COLLECT) && !fifo_empty &&
                  (div_cnt_q == DIV_LAST);

    assign head_word   = mem_q[rd_ptr_q[AW-1:0]];
    assign sig_next    = {sig_q[1:63], sig_q[0]} ^ head_word;
    assign pop_cnt_inc = pop_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push_cnt_d = push_cnt_q;
        div_cnt_d  = div_cnt_q;
        sig_d      = sig_q;
        pop_cnt_d  = pop_cnt_q;

        case (state_q)
            ST_COLLECT: begin
                if (fifo_empty) begin
                    div_cnt_d = '0;
                end else if (pop) begin
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end

                if (push) begin
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    push_cnt_d = push_cnt_q + 8'd1;
                end

                if (pop) begin
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    sig_d     = sig_next;
                    pop_cnt_d = pop_cnt_inc;
                    if (pop_cnt_inc == FRAME_CNT) begin
                        state_d = (sig_next == EXPECTED_SIG) ? ST_PASS : ST_FAIL;
                    end
                end
            end

            default: begin
                if (START) begin
                    state_d    = ST_COLLECT;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    push_cnt_d = '0;
                    div_cnt_d  = '0;
                    sig_d      = '0;
                    pop_cnt_d  = '0;
                end
            end
        endcase

        // LEDs are registered from the next state so they change on the
        // same edge as the state itself.
        led_d = {state_d == ST_FAIL, state_d == ST_PASS, state_d == ST_COLLECT};
    end

    always_ff @(posedge D_CLK) begin
        if (D_OFF) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            push_cnt_q <= '0;
            div_cnt_q  <= '0;
            sig_q      <= '0;
            pop_cnt_q  <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            push_cnt_q <= push_cnt_d;
            div_cnt_q  <= div_cnt_d;
            sig_q      <= sig_d;
            pop_cnt_q  <= pop_cnt_d;
            led_q      <= led_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge D_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= IN_DATA;
        end
    end

    assign IN_READY = in_ready;
    assign SIG      = sig_q;
    assign POP_CNT  = pop_cnt_q;
    assign LED_0    = led_q[0];
    assign LED_1    = led_q[1];
    assign LED_2    = led_q[2];

endmodule

// File: tb/tb_mmu_result_monitor.sv
module tb_mmu_result_monitor;

    localparam logic [63:0] EXP_B = 64'hC0FF_EE12_3456_789A;

    logic        D_CLK = 1'b0;
    logic        D_OFF;
    logic        start [2];
    logic        valid [2];
    logic [63:0] data  [2];
    logic        rdy   [2];
    logic [63:0] sg    [2];
    logic [7:0]  pc    [2];
    logic        l0    [2];
    logic        l1    [2];
    logic        l2    [2];

    int checks = 0;
    int errors = 0;

    always #5 D_CLK = ~D_CLK;

    // Instance 0: FRAME_WORDS=2, DRAIN_DIV=1, golden 0.
    mmu_result_monitor #(
        .FRAME_WORDS(2), .FIFO_DEPTH(4), .DRAIN_DIV(1), .EXPECTED_SIG(64'h0)
    ) u_a (
        .D_CLK(D_CLK), .D_OFF(D_OFF), .START(start[0]), .IN_VALID(valid[0]),
        .IN_DATA(data[0]), .IN_READY(rdy[0]), .SIG(sg[0]), .POP_CNT(pc[0]),
        .LED_0(l0[0]), .LED_1(l1[0]), .LED_2(l2[0])
    );

    // Instance 1: FRAME_WORDS=8, FIFO_DEPTH=4, DRAIN_DIV=4.
    mmu_result_monitor #(
        .FRAME_WORDS(8), .FIFO_DEPTH(4), .DRAIN_DIV(4), .EXPECTED_SIG(EXP_B)
    ) u_b (
        .D_CLK(D_CLK), .D_OFF(D_OFF), .START(start[1]), .IN_VALID(valid[1]),
        .IN_DATA(data[1]), .IN_READY(rdy[1]), .SIG(sg[1]), .POP_CNT(pc[1]),
        .LED_0(l0[1]), .LED_1(l1[1]), .LED_2(l2[1])
    );

    // ---------------- reference model ----------------
    logic [63:0] mq [2][$];
    int          m_pushed [2];
    int          m_popped [2];
    int          m_wait   [2];
    logic [63:0] m_sig    [2];
    bit          m_busy   [2];
    bit          m_pass   [2];
    bit          m_fail   [2];

    function automatic int p_fw(int i);
        return (i == 0) ? 2 : 8;
    endfunction
    function automatic int p_dd(int i);
        return (i == 0) ? 1 : 4;
    endfunction
    function automatic logic [63:0] p_exp(int i);
        return (i == 0) ? 64'h0 : EXP_B;
    endfunction

    function automatic logic [63:0] rotl(logic [63:0] s);
        return (s << 1) | (s >> 63);
    endfunction

    function automatic bit m_ready(int i);
        return m_busy[i] && (mq[i].size() < 4) && (m_pushed[i] < p_fw(i));
    endfunction

    function automatic logic [75:0] mvec(int i);
        return {m_ready(i), m_busy[i], m_pass[i], m_fail[i], 8'(m_popped[i]), m_sig[i]};
    endfunction

    function automatic logic [75:0] dvec(int i);
        return {rdy[i], l0[i], l1[i], l2[i], pc[i], sg[i]};
    endfunction

    // Advance one clock: model takes the inputs present at the rising edge,
    // then return at the falling edge where outputs are compared.
    task automatic tick();
        @(posedge D_CLK);
        for (int i = 0; i < 2; i++) begin
            bit          rd;
            bit          popn;
            logic [63:0] w;
            if (D_OFF) begin
                mq[i].delete();
                m_pushed[i] = 0; m_popped[i] = 0; m_wait[i] = 0; m_sig[i] = '0;
                m_busy[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
            end else if (!m_busy[i]) begin
                if (start[i]) begin
                    mq[i].delete();
                    m_pushed[i] = 0; m_popped[i] = 0; m_wait[i] = 0; m_sig[i] = '0;
                    m_busy[i] = 1; m_pass[i] = 0; m_fail[i] = 0;
                end
            end else begin
                rd   = m_ready(i);
                popn = 0;
                // head word leaves once it has waited DRAIN_DIV cycles
                if (mq[i].size() == 0) begin
                    m_wait[i] = 0;
                end else begin
                    m_wait[i]++;
                    if (m_wait[i] == p_dd(i)) begin
                        popn = 1;
                        m_wait[i] = 0;
                    end
                end
                if (popn) begin
                    w = mq[i].pop_front();
                    m_sig[i] = rotl(m_sig[i]) ^ w;
                    m_popped[i]++;
                    if (m_popped[i] == p_fw(i)) begin
                        m_busy[i] = 0;
                        m_pass[i] = (m_sig[i] == p_exp(i));
                        m_fail[i] = !m_pass[i];
                    end
                end
                if (valid[i] && rd) begin
                    mq[i].push_back(data[i]);
                    m_pushed[i]++;
                end
            end
        end
        @(negedge D_CLK);
    endtask

    // ---------------- frame stimulus ----------------
    logic [63:0] frame_w [$];
    logic [63:0] sig_trace [$];
    int          g_dut_acc;
    int          g_drop;

    function automatic logic [63:0] fold_n(int n);
        logic [63:0] s = '0;
        for (int k = 0; k < n; k++) s = rotl(s) ^ frame_w[k];
        return s;
    endfunction

    task automatic build_words(input int i, input int n, input bit want_pass);
        frame_w.delete();
        for (int k = 0; k < n; k++) frame_w.push_back({$urandom, $urandom});
        if (want_pass) frame_w[p_fw(i)-1] = rotl(fold_n(p_fw(i)-1)) ^ p_exp(i);
    endtask

    // Runs one frame on instance i from frame_w, comparing every cycle.
    task automatic run_frame(input int i, input int vprob, input int mid_start);
        int idx = 0;
        int cyc = 0;
        logic [7:0] last_pc = 8'd0;
        bit macc;
        g_dut_acc = 0;
        g_drop    = -1;
        sig_trace.delete();
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        checks++;
        if (dvec(i) !== mvec(i)) begin
            errors++;
            $display("FAIL start inst=%0d got %h want %h", i, dvec(i), mvec(i));
        end
        while (m_busy[i] && cyc < 400) begin
            valid[i] = (idx < frame_w.size()) && ($urandom_range(99) < vprob);
            data[i]  = valid[i] ? frame_w[idx] : {$urandom, $urandom};
            start[i] = (mid_start > 0) && (cyc == mid_start);
            macc     = valid[i] && m_ready(i);
            if (valid[i] && rdy[i] === 1'b1) g_dut_acc++;
            tick();
            if (macc) idx++;
            if (g_drop < 0 && g_dut_acc > 0 && rdy[i] === 1'b0) g_drop = g_dut_acc;
            if (pc[i] !== last_pc) begin
                sig_trace.push_back(sg[i]);
                last_pc = pc[i];
            end
            checks++;
            if (dvec(i) !== mvec(i)) begin
                errors++;
                $display("FAIL cycle inst=%0d cyc=%0d got %h want %h", i, cyc, dvec(i), mvec(i));
            end
            cyc++;
        end
        start[i] = 1'b0;
        valid[i] = 1'b0;
        if (cyc >= 400) begin
            errors++;
            $display("FAIL timeout inst=%0d frame never finished, pops %0d want %0d", i, pc[i], p_fw(i));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        D_OFF = 1'b1;
        valid[0] = 1'b1; valid[1] = 1'b1;
        data[0] = {$urandom, $urandom}; data[1] = {$urandom, $urandom};
        for (int c = 0; c < 4; c++) begin
            if (c == 2) D_OFF = 1'b0;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dvec(i) !== 76'h0) begin
                    errors++;
                    $display("FAIL reset_idle inst=%0d c=%0d got %h want 0", i, c, dvec(i));
                end
            end
        end
        valid[0] = 1'b0; valid[1] = 1'b0;
    endtask

    task automatic test_pass_frame();
        frame_w = '{64'h1, 64'h2};
        run_frame(0, 100, 0);
        checks++;
        if (sig_trace.size() != 2 || sig_trace[0] !== 64'h1 || sig_trace[1] !== 64'h0) begin
            errors++;
            $display("FAIL pass_trace got %p want '{1,0}", sig_trace);
        end
        checks++;
        if ({l0[0], l1[0], l2[0], pc[0], sg[0]} !== {3'b010, 8'd2, 64'h0}) begin
            errors++;
            $display("FAIL pass_final got %b%b%b pc=%0d sig=%h want 010 pc=2 sig=0",
                     l0[0], l1[0], l2[0], pc[0], sg[0]);
        end
    endtask

    task automatic test_fail_frame();
        frame_w = '{64'h1, 64'h3};
        run_frame(0, 100, 0);
        checks++;
        if ({l0[0], l1[0], l2[0], pc[0], sg[0]} !== {3'b001, 8'd2, 64'h1}) begin
            errors++;
            $display("FAIL fail_final got %b%b%b pc=%0d sig=%h want 001 pc=2 sig=1",
                     l0[0], l1[0], l2[0], pc[0], sg[0]);
        end
    endtask

    task automatic test_back_pressure();
        build_words(1, 8, 1'b1);
        run_frame(1, 100, 0);
        checks++;
        if (g_drop !== 4) begin
            errors++;
            $display("FAIL bp_first_drop got %0d pushes want 4", g_drop);
        end
        checks++;
        if (g_dut_acc !== 8 || sg[1] !== EXP_B || l1[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_final acc=%0d sig=%h led1=%b want acc=8 sig=%h led1=1",
                     g_dut_acc, sg[1], l1[1], EXP_B);
        end
    endtask

    task automatic test_frame_limit();
        logic [63:0] f;
        build_words(1, 10, 1'b0);
        f = fold_n(8);
        run_frame(1, 100, 0);
        checks++;
        if (g_dut_acc !== 8 || sg[1] !== f || pc[1] !== 8'd8) begin
            errors++;
            $display("FAIL limit_final acc=%0d sig=%h pc=%0d want acc=8 sig=%h pc=8",
                     g_dut_acc, sg[1], pc[1], f);
        end
        valid[1] = 1'b1;
        data[1]  = frame_w[8];
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (rdy[1] !== 1'b0 || pc[1] !== 8'd8 || sg[1] !== f) begin
                errors++;
                $display("FAIL limit_hold c=%0d rdy=%b pc=%0d got sig %h want rdy=0 pc=8 sig %h",
                         c, rdy[1], pc[1], sg[1], f);
            end
        end
        valid[1] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int idx = 0;
        int cyc = 0;
        bit macc;
        build_words(1, 8, 1'b0);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        while (pc[1] !== 8'd2 && cyc < 100) begin
            valid[1] = 1'b1;
            data[1]  = frame_w[idx];
            macc     = m_ready(1);
            tick();
            if (macc) idx++;
            checks++;
            if (dvec(1) !== mvec(1)) begin
                errors++;
                $display("FAIL midrst_cycle cyc=%0d got %h want %h", cyc, dvec(1), mvec(1));
            end
            cyc++;
        end
        if (cyc >= 100) begin
            errors++;
            $display("FAIL midrst_timeout pops %0d want 2", pc[1]);
        end
        D_OFF = 1'b1;
        tick();
        D_OFF = 1'b0;
        valid[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dvec(i) !== 76'h0) begin
                errors++;
                $display("FAIL midrst_zero inst=%0d got %h want 0", i, dvec(i));
            end
        end
        build_words(1, 8, 1'b1);
        run_frame(1, 70, 9);
        checks++;
        if (sg[1] !== EXP_B || pc[1] !== 8'd8 || {l0[1], l1[1], l2[1]} !== 3'b010) begin
            errors++;
            $display("FAIL midrst_restart sig=%h pc=%0d leds=%b%b%b want sig=%h pc=8 leds=010",
                     sg[1], pc[1], l0[1], l1[1], l2[1], EXP_B);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            int          i    = n % 2;
            bit          want = $urandom_range(1);
            logic [63:0] f;
            build_words(i, p_fw(i) + $urandom_range(2), want);
            f = fold_n(p_fw(i));
            run_frame(i, $urandom_range(100, 40), (n == 3) ? 4 : 0);
            checks++;
            if (sg[i] !== f || pc[i] !== 8'(p_fw(i)) ||
                {l0[i], l1[i], l2[i]} !== {1'b0, f == p_exp(i), f != p_exp(i)}) begin
                errors++;
                $display("FAIL b2b n=%0d inst=%0d sig=%h pc=%0d leds=%b%b%b want sig=%h pc=%0d",
                         n, i, sg[i], pc[i], l0[i], l1[i], l2[i], f, p_fw(i));
            end
        end
    endtask

    initial begin
        D_OFF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        test_reset();
        test_pass_frame();
        test_fail_frame();
        test_back_pressure();
        test_frame_limit();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
